// File: rtl/arm_pkg.sv
// Shared widths, encodings and ID/EXE field-group structs for the ARM-subset core.
package arm_pkg;

    localparam int REG_IDX_W  = 4;
    localparam int WORD_W     = 32;
    localparam int EXE_CMD_W  = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;

    localparam logic [EXE_CMD_W-1:0] EXE_CMD_NOP = 4'b0000;

    // Control group: everything that can cause an architectural side effect.
    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
        logic                 imm;
        logic                 c;
    } ctrl_t;

    // Data group: operand values, PC and immediate fields.
    typedef struct packed {
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     val_rn;
        logic [WORD_W-1:0]     val_rm;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic [IMM24_W-1:0]    signed_imm_24;
    } data_t;

    // Index group: register numbers used by write-back and forwarding.
    typedef struct packed {
        logic [REG_IDX_W-1:0] dest;
        logic [REG_IDX_W-1:0] src1;
        logic [REG_IDX_W-1:0] src2;
    } idx_t;

endpackage

// File: rtl/pipe_reg.sv
// Parameterised-width pipeline register: reset dominates, en=0 holds, clr zeroes on an enabled edge.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Register the field group with rst > hold > clear > load priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every stage register samples pre-edge values regardless of block order.
        if (rst) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= clr ? '0 : d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with freeze, flush, valid tracking and saturating bubble/flush counters.
module id_exe_reg
    import arm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  hazard_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
    input  logic [WORD_W-1:0]     pc_in,
    input  logic [WORD_W-1:0]     val_rn_in,
    input  logic [WORD_W-1:0]     val_rm_in,
    input  logic [REG_IDX_W-1:0]  dest_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [IMM24_W-1:0]    signed_imm_24_in,
    input  logic                  imm_in,
    input  logic                  c_in,
    input  logic [REG_IDX_W-1:0]  src1_in,
    input  logic [REG_IDX_W-1:0]  src2_in,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [EXE_CMD_W-1:0]  exe_cmd_out,
    output logic [WORD_W-1:0]     pc_out,
    output logic [WORD_W-1:0]     val_rn_out,
    output logic [WORD_W-1:0]     val_rm_out,
    output logic [REG_IDX_W-1:0]  dest_out,
    output logic [SHIFT_OP_W-1:0] shift_operand_out,
    output logic [IMM24_W-1:0]    signed_imm_24_out,
    output logic                  imm_out,
    output logic                  c_out,
    output logic [REG_IDX_W-1:0]  src1_out,
    output logic [REG_IDX_W-1:0]  src2_out,
    output logic                  valid_out,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_t w_ctrl_d, w_ctrl_q;
    data_t w_data_d, w_data_q;
    idx_t  w_idx_d,  w_idx_q;
    logic  w_en;

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // A frozen stage ignores flush; upstream keeps flush asserted until freeze drops.
    assign w_en = ~freeze;

    // Controls are captured as-is during a hazard; decode already zeroed them.
    assign w_ctrl_d = '{
        valid:    ~hazard_in,
        wb_en:    wb_en_in,
        mem_r_en: mem_r_en_in,
        mem_w_en: mem_w_en_in,
        b:        b_in,
        s:        s_in,
        exe_cmd:  exe_cmd_in,
        imm:      imm_in,
        c:        c_in
    };

    assign w_data_d = '{
        pc:            pc_in,
        val_rn:        val_rn_in,
        val_rm:        val_rm_in,
        shift_operand: shift_operand_in,
        signed_imm_24: signed_imm_24_in
    };

    assign w_idx_d = '{
        dest: dest_in,
        src1: src1_in,
        src2: src2_in
    };

    pipe_reg #(.W($bits(ctrl_t))) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   (w_ctrl_d),
        .q   (w_ctrl_q)
    );

    pipe_reg #(.W($bits(data_t))) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   (w_data_d),
        .q   (w_data_q)
    );

    pipe_reg #(.W($bits(idx_t))) u_idx_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_en),
        .clr (flush),
        .d   (w_idx_d),
        .q   (w_idx_q)
    );

    // Count accepted flushes and accepted decode bubbles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!freeze) begin
            if (flush) begin
                if (r_flush_cnt != CNT_MAX) begin
                    r_flush_cnt <= r_flush_cnt + CNT_W'(1);
                end
            end else if (hazard_in && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign valid_out         = w_ctrl_q.valid;
    assign wb_en_out         = w_ctrl_q.wb_en;
    assign mem_r_en_out      = w_ctrl_q.mem_r_en;
    assign mem_w_en_out      = w_ctrl_q.mem_w_en;
    assign b_out             = w_ctrl_q.b;
    assign s_out             = w_ctrl_q.s;
    assign exe_cmd_out       = w_ctrl_q.exe_cmd;
    assign imm_out           = w_ctrl_q.imm;
    assign c_out             = w_ctrl_q.c;
    assign pc_out            = w_data_q.pc;
    assign val_rn_out        = w_data_q.val_rn;
    assign val_rm_out        = w_data_q.val_rm;
    assign shift_operand_out = w_data_q.shift_operand;
    assign signed_imm_24_out = w_data_q.signed_imm_24;
    assign dest_out          = w_idx_q.dest;
    assign src1_out          = w_idx_q.src1;
    assign src2_out          = w_idx_q.src2;
    assign bubble_cnt        = r_bubble_cnt;
    assign flush_cnt         = r_flush_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed table, saturation sequence, randomized run vs event-count model.
module tb_id_exe_reg;
    import arm_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        freeze;
        logic        flush;
        logic        hazard;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  dest;
        logic [11:0] shift_op;
        logic [23:0] imm24;
        logic        imm;
        logic        c;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  dest;
        logic [11:0] shift_op;
        logic [23:0] imm24;
        logic        imm;
        logic        c;
        logic [3:0]  src1;
        logic [3:0]  src2;
    } fields_t;

    typedef struct packed {
        in_t         in;
        logic [31:0] pc;
        logic        valid;
        logic [15:0] bub;
        logic [15:0] fl;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t stim = '0;

    wire fields_t    o1;
    wire [15:0]      b1, f1;
    wire fields_t    o2;
    wire [1:0]       b2, f2;

    int checks = 0;
    int errors = 0;

    // Reference state: the last accepted instruction and plain event counts since reset.
    fields_t m_f = '0;
    int      n_bub = 0;
    int      n_fl  = 0;

    id_exe_reg #(.CNT_W(16)) dut (
        .clk(clk), .rst(stim.rst), .freeze(stim.freeze), .flush(stim.flush), .hazard_in(stim.hazard),
        .wb_en_in(stim.wb_en), .mem_r_en_in(stim.mem_r_en), .mem_w_en_in(stim.mem_w_en),
        .b_in(stim.b), .s_in(stim.s), .exe_cmd_in(stim.exe_cmd), .pc_in(stim.pc),
        .val_rn_in(stim.val_rn), .val_rm_in(stim.val_rm), .dest_in(stim.dest),
        .shift_operand_in(stim.shift_op), .signed_imm_24_in(stim.imm24), .imm_in(stim.imm),
        .c_in(stim.c), .src1_in(stim.src1), .src2_in(stim.src2),
        .wb_en_out(o1.wb_en), .mem_r_en_out(o1.mem_r_en), .mem_w_en_out(o1.mem_w_en),
        .b_out(o1.b), .s_out(o1.s), .exe_cmd_out(o1.exe_cmd), .pc_out(o1.pc),
        .val_rn_out(o1.val_rn), .val_rm_out(o1.val_rm), .dest_out(o1.dest),
        .shift_operand_out(o1.shift_op), .signed_imm_24_out(o1.imm24), .imm_out(o1.imm),
        .c_out(o1.c), .src1_out(o1.src1), .src2_out(o1.src2), .valid_out(o1.valid),
        .bubble_cnt(b1), .flush_cnt(f1)
    );

    id_exe_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(stim.rst), .freeze(stim.freeze), .flush(stim.flush), .hazard_in(stim.hazard),
        .wb_en_in(stim.wb_en), .mem_r_en_in(stim.mem_r_en), .mem_w_en_in(stim.mem_w_en),
        .b_in(stim.b), .s_in(stim.s), .exe_cmd_in(stim.exe_cmd), .pc_in(stim.pc),
        .val_rn_in(stim.val_rn), .val_rm_in(stim.val_rm), .dest_in(stim.dest),
        .shift_operand_in(stim.shift_op), .signed_imm_24_in(stim.imm24), .imm_in(stim.imm),
        .c_in(stim.c), .src1_in(stim.src1), .src2_in(stim.src2),
        .wb_en_out(o2.wb_en), .mem_r_en_out(o2.mem_r_en), .mem_w_en_out(o2.mem_w_en),
        .b_out(o2.b), .s_out(o2.s), .exe_cmd_out(o2.exe_cmd), .pc_out(o2.pc),
        .val_rn_out(o2.val_rn), .val_rm_out(o2.val_rm), .dest_out(o2.dest),
        .shift_operand_out(o2.shift_op), .signed_imm_24_out(o2.imm24), .imm_out(o2.imm),
        .c_out(o2.c), .src1_out(o2.src1), .src2_out(o2.src2), .valid_out(o2.valid),
        .bubble_cnt(b2), .flush_cnt(f2)
    );

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        return (n > max_v) ? max_v : n;
    endfunction

    function automatic fields_t to_fields(input in_t v);
        fields_t f;
        f.valid    = ~v.hazard;
        f.wb_en    = v.wb_en;
        f.mem_r_en = v.mem_r_en;
        f.mem_w_en = v.mem_w_en;
        f.b        = v.b;
        f.s        = v.s;
        f.exe_cmd  = v.exe_cmd;
        f.pc       = v.pc;
        f.val_rn   = v.val_rn;
        f.val_rm   = v.val_rm;
        f.dest     = v.dest;
        f.shift_op = v.shift_op;
        f.imm24    = v.imm24;
        f.imm      = v.imm;
        f.c        = v.c;
        f.src1     = v.src1;
        f.src2     = v.src2;
        return f;
    endfunction

    // One edge of the reference: reset, hold, bubble-by-flush, or accept the decode outputs.
    task automatic model_step(input in_t v);
        if (v.rst) begin
            m_f   = '0;
            n_bub = 0;
            n_fl  = 0;
        end else if (v.freeze) begin
            m_f = m_f;
        end else if (v.flush) begin
            m_f = '0;
            n_fl++;
        end else begin
            m_f = to_fields(v);
            if (v.hazard) n_bub++;
        end
    endtask

    // Random decode outputs with all sideband controls (rst/freeze/flush/hazard) low.
    function automatic in_t rand_in(input logic [31:0] pc);
        logic [191:0] r;
        in_t v;
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = $urandom;
        v        = in_t'(r[$bits(in_t)-1:0]);
        v.rst    = 1'b0;
        v.freeze = 1'b0;
        v.flush  = 1'b0;
        v.hazard = 1'b0;
        v.pc     = pc;
        return v;
    endfunction

    function automatic in_t bubble_in(input logic [31:0] pc);
        in_t v;
        v          = rand_in(pc);
        v.hazard   = 1'b1;
        v.wb_en    = 1'b0;
        v.mem_r_en = 1'b0;
        v.mem_w_en = 1'b0;
        v.b        = 1'b0;
        v.s        = 1'b0;
        v.exe_cmd  = EXE_CMD_NOP;
        return v;
    endfunction

    // Apply one input vector across an edge, then compare both DUTs with the model.
    task automatic cycle(input in_t v, input string tag);
        stim = v;
        @(posedge clk);
        model_step(v);
        #1;
        check({tag, " full"}, {o1, b1, f1}, {m_f, 16'(sat(n_bub, 16)), 16'(sat(n_fl, 16))});
        check({tag, " cnt2"}, {o2, b2, f2}, {m_f, 2'(sat(n_bub, 2)), 2'(sat(n_fl, 2))});
    endtask

    vec_t tbl[17];

    initial begin
        in_t v;
        logic [1:0] sat_exp [5];

        // Directed table: each row is one clock edge with hand-derived expectations.
        v = '1;
        tbl[0] = '{in: v, pc: 32'h0, valid: 1'b0, bub: 16'd0, fl: 16'd0};
        tbl[1] = '{in: v, pc: 32'h0, valid: 1'b0, bub: 16'd0, fl: 16'd0};
        v = rand_in(32'h10);
        v.val_rn = 32'h1234_5678; v.exe_cmd = 4'b0010; v.wb_en = 1'b1;
        tbl[2] = '{in: v, pc: 32'h10, valid: 1'b1, bub: 16'd0, fl: 16'd0};
        tbl[3] = '{in: rand_in(32'h20), pc: 32'h20, valid: 1'b1, bub: 16'd0, fl: 16'd0};
        for (int i = 4; i < 7; i++) begin
            v = rand_in(32'h24); v.freeze = 1'b1;
            tbl[i] = '{in: v, pc: 32'h20, valid: 1'b1, bub: 16'd0, fl: 16'd0};
        end
        v = rand_in(32'h24); v.freeze = 1'b1; v.flush = 1'b1;
        tbl[7] = '{in: v, pc: 32'h20, valid: 1'b1, bub: 16'd0, fl: 16'd0};
        v = rand_in(32'h28); v.mem_w_en = 1'b1; v.dest = 4'd5; v.flush = 1'b1;
        tbl[8] = '{in: v, pc: 32'h0, valid: 1'b0, bub: 16'd0, fl: 16'd1};
        tbl[9] = '{in: rand_in(32'h2c), pc: 32'h2c, valid: 1'b1, bub: 16'd0, fl: 16'd1};
        for (int i = 0; i < 4; i++) begin
            tbl[10+i] = '{in: bubble_in(32'h30 + 32'(4*i)), pc: 32'h30 + 32'(4*i),
                          valid: 1'b0, bub: 16'(i+1), fl: 16'd1};
        end
        v = rand_in(32'h40); v.freeze = 1'b1;
        tbl[14] = '{in: v, pc: 32'h3c, valid: 1'b0, bub: 16'd4, fl: 16'd1};
        v = rand_in(32'h44); v.freeze = 1'b1; v.rst = 1'b1;
        tbl[15] = '{in: v, pc: 32'h0, valid: 1'b0, bub: 16'd0, fl: 16'd0};
        tbl[16] = '{in: rand_in(32'h48), pc: 32'h48, valid: 1'b1, bub: 16'd0, fl: 16'd0};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].in, $sformatf("row%0d", i));
            check($sformatf("row%0d pc", i),    192'(o1.pc),    192'(tbl[i].pc));
            check($sformatf("row%0d valid", i), 192'(o1.valid), 192'(tbl[i].valid));
            check($sformatf("row%0d bubble", i), 192'(b1),      192'(tbl[i].bub));
            check($sformatf("row%0d flush", i),  192'(f1),      192'(tbl[i].fl));
            if (i == 8) check("flush clears all fields", 192'(o1), 192'(0));
        end

        // Saturation on the 2-bit instance: 1,2,3,3,3 then reset back to 0.
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        v = rand_in(32'h0); v.rst = 1'b1;
        cycle(v, "sat reset");
        for (int i = 0; i < 5; i++) begin
            v = rand_in(32'h100 + 32'(i)); v.flush = 1'b1;
            cycle(v, $sformatf("sat flush%0d", i));
            check($sformatf("sat flush_cnt%0d", i), 192'(f2), 192'(sat_exp[i]));
        end
        v = rand_in(32'h200); v.rst = 1'b1;
        cycle(v, "sat clear");
        check("sat flush_cnt after rst", 192'(f2), 192'(0));

        // Randomized traffic against the event-count model.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) v = bubble_in($urandom);
            else                        v = rand_in($urandom);
            v.rst    = ($urandom_range(63) == 0);
            v.freeze = ($urandom_range(3) == 0);
            v.flush  = ($urandom_range(5) == 0);
            cycle(v, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM-subset core.
- Captures every decode output (control, operands, register indices, PC) on each clock edge.
- Supports freeze (memory stall) and flush (taken branch), tracks a valid bit, and keeps saturating counters of inserted bubbles and flushes for performance debug.

Parameters:
- CNT_W, 16, width of the bubble/flush performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  hold all state this cycle (memory stage busy)
- flush  in  1  taken branch in EXE; kill the instruction entering
- hazard_in  in  1  decode stage is emitting a bubble this cycle
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  decoded control
- exe_cmd_in  in  4  ALU command
- pc_in  in  32  PC of the instruction
- val_rn_in, val_rm_in  in  32 each  register-file read values
- dest_in  in  4  destination register
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- imm_in, c_in  in  1 each  immediate flag, carry from status register
- src1_in, src2_in  in  4 each  source register indices (for forwarding)
- all of the above with suffix _out  out  same widths  registered copies
- valid_out  out  1  EXE holds a real instruction
- bubble_cnt  out  CNT_W  bubbles accepted since reset
- flush_cnt  out  CNT_W  flushes accepted since reset

Behaviour:
- One clock, synchronous active-high reset. All outputs change only on the rising edge of clk.
- Latency: 1 cycle, input to _out.
- Per-edge priority is rst > freeze > flush > load.
- rst=1:
  - every _out, valid_out, bubble_cnt and flush_cnt become 0.
  - freeze and flush are ignored that cycle.
- freeze=1 (rst=0):
  - all registers, counters and valid_out hold.
  - a simultaneous flush is ignored; upstream holds flush until freeze drops.
- flush=1, freeze=0:
  - every _out field and valid_out are cleared to 0. This is a bubble: no write-back, no memory access, no branch, no S update.
  - flush_cnt increments by 1, saturating at all-ones.
  - bubble_cnt is unchanged.
- Load (rst=0, freeze=0, flush=0):
  - every _out takes its _in value.
  - valid_out takes ~hazard_in.
  - if hazard_in=1, bubble_cnt increments by 1, saturating at all-ones.
  - control inputs are already zero during a hazard; they are captured as-is and not re-masked.
- Counter saturation: at 2^CNT_W-1 the counter holds; it never wraps.
- Reset mid-stall: rst overrides freeze; the next cycle with freeze=0 loads normally.
- No combinational path from any input to any output.

Decomposition:
- Shared package `arm_pkg` holds:
  - width constants: REG_IDX_W=4, WORD_W=32, EXE_CMD_W=4, SHIFT_OP_W=12, IMM24_W=24
  - EXE_CMD_NOP=4'b0000
- One natural sub-module: `pipe_reg`, a parameterised-width register with ports clk, rst, en, clr, d, q.
  - rst or clr forces zero; en=0 holds.
  - It is instantiated once per field group: control, data, index.
- The counters are written inline.

Test Plan:
- Reset: drive all _in nonzero with rst=1 for 2 cycles -> every _out, valid_out, bubble_cnt and flush_cnt read 0 after the edge.
- Plain load: pc_in=0x0000_0010, val_rn_in=0x1234_5678, exe_cmd_in=4'b0010, wb_en_in=1, hazard_in=0 -> next cycle the _out fields match, valid_out=1, both counters stay 0.
- Freeze:
  - load pc_in=0x20, then assert freeze for 3 cycles while changing pc_in to 0x24 -> pc_out stays 0x20 and valid_out stays 1 for all 3 cycles.
  - with freeze=1 and flush=1 together -> nothing changes and flush_cnt stays 0.
- Flush:
  - load mem_w_en_in=1, dest_in=4'd5, flush=1 -> next cycle all _out=0, valid_out=0, flush_cnt=1.
  - next cycle with flush=0 -> the new input loads normally.
- Hazard bubble: hazard_in=1 with all controls 0 for 4 consecutive cycles -> valid_out=0 and bubble_cnt reaches 4.
  - then hazard_in=0 with freeze=1 -> bubble_cnt stays 4.
- Saturation: CNT_W=2, apply 5 flush cycles -> flush_cnt reads 1,2,3,3,3.
  - then rst=1 -> flush_cnt=0.
